// File: rtl/sdram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_slot_arbiter
// Description : Slot-based front end for the SDRAM controller. The SDRAM
//               clock is divided into fixed-length access slots. At every
//               slot start one of refresh / chipset / CPU / nothing is
//               granted and the controller command inputs are loaded for the
//               whole slot. Read data is captured at a fixed slot offset and
//               returned to the granted client together with a one-cycle ack.
// Ports       : clk, reset_n (async, active low), ready (controller init done)
//               sync/cs/we/refresh/addr/ds/din -> controller command inputs
//               dout                           <- controller read data
//               chip_* / cpu_*                 client request/ack/data ports
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_slot_arbiter #(
  parameter int SLOT_CYCLES   = 10,
  parameter int DOUT_LAT      = 8,
  parameter int REFRESH_SLOTS = 32,
  parameter int REFRESH_MAX   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  output logic        sync,
  output logic        cs,
  output logic        we,
  output logic        refresh,
  output logic [21:0] addr,
  output logic [1:0]  ds,
  output logic [15:0] din,
  input  logic [15:0] dout,
  input  logic        chip_req,
  input  logic        chip_we,
  input  logic [21:0] chip_addr,
  input  logic [1:0]  chip_ds,
  input  logic [15:0] chip_din,
  output logic        chip_ack,
  output logic [15:0] chip_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout
);

  localparam int CNT_W = 4;  // SLOT_CYCLES is at most 15
  localparam int REF_W = (REFRESH_SLOTS > 2) ? $clog2(REFRESH_SLOTS) : 1;
  localparam int DEF_W = $clog2(REFRESH_MAX + 1);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SLOT_CYCLES / 2);
  localparam logic [CNT_W-1:0] DOUT_IDX  = CNT_W'(DOUT_LAT);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_SLOTS - 1);
  localparam logic [DEF_W-1:0] DEF_LIMIT = DEF_W'(REFRESH_MAX);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_REF  = 2'd1;
  localparam logic [1:0] GNT_CHIP = 2'd2;
  localparam logic [1:0] GNT_CPU  = 2'd3;

  logic [CNT_W-1:0] slot_cnt, slot_cnt_d;
  logic             started, started_d;
  logic [1:0]       grant, grant_d;
  logic [REF_W-1:0] ref_cnt, ref_cnt_d;
  logic             ref_pend, ref_pend_d;
  logic [DEF_W-1:0] defer_cnt, defer_cnt_d;
  logic             slot_start;

  logic        sync_d, cs_d, we_d, refresh_d;
  logic [21:0] addr_d;
  logic [1:0]  ds_d;
  logic [15:0] din_d;
  logic        chip_ack_d, cpu_ack_d;
  logic [15:0] chip_dout_d, cpu_dout_d;

  // A slot begins on the wrap to 0, or on the first edge after ready rises
  // (started remembers whether the previous edge already saw ready).
  assign slot_start = ready && (!started || (slot_cnt == SLOT_LAST));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt  <= '0;
      started   <= 1'b0;
      grant     <= GNT_NONE;
      ref_cnt   <= '0;
      ref_pend  <= 1'b0;
      defer_cnt <= '0;
      sync      <= 1'b0;
      cs        <= 1'b0;
      we        <= 1'b0;
      refresh   <= 1'b0;
      addr      <= '0;
      ds        <= '0;
      din       <= '0;
      chip_ack  <= 1'b0;
      cpu_ack   <= 1'b0;
      chip_dout <= '0;
      cpu_dout  <= '0;
    end else begin
      slot_cnt  <= slot_cnt_d;
      started   <= started_d;
      grant     <= grant_d;
      ref_cnt   <= ref_cnt_d;
      ref_pend  <= ref_pend_d;
      defer_cnt <= defer_cnt_d;
      sync      <= sync_d;
      cs        <= cs_d;
      we        <= we_d;
      refresh   <= refresh_d;
      addr      <= addr_d;
      ds        <= ds_d;
      din       <= din_d;
      chip_ack  <= chip_ack_d;
      cpu_ack   <= cpu_ack_d;
      chip_dout <= chip_dout_d;
      cpu_dout  <= cpu_dout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: slot counter, grant selection, refresh scheduler
  // --------------------------------------------------------------------------
  always_comb begin
    slot_cnt_d  = slot_cnt;
    started_d   = ready;
    grant_d     = grant;
    ref_cnt_d   = ref_cnt;
    ref_pend_d  = ref_pend;
    defer_cnt_d = defer_cnt;
    if (!ready) begin
      slot_cnt_d = '0;
      grant_d    = GNT_NONE;
    end else begin
      slot_cnt_d = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + CNT_W'(1);
      if (slot_start) begin
        if (ref_pend && ((defer_cnt == DEF_LIMIT) || !chip_req)) begin
          grant_d     = GNT_REF;
          ref_pend_d  = 1'b0;
          defer_cnt_d = '0;
        end else if (chip_req) begin
          grant_d = GNT_CHIP;
          if (ref_pend) defer_cnt_d = defer_cnt + DEF_W'(1);
        end else if (cpu_req) begin
          grant_d = GNT_CPU;
        end else begin
          grant_d = GNT_NONE;
        end
        // A request maturing while one is still pending simply merges into it.
        if (ref_cnt == REF_LAST) begin
          ref_cnt_d  = '0;
          ref_pend_d = 1'b1;
        end else begin
          ref_cnt_d = ref_cnt + REF_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: command fields, sync, acks and read-data capture
  // --------------------------------------------------------------------------
  always_comb begin
    cs_d        = cs;
    we_d        = we;
    refresh_d   = refresh;
    addr_d      = addr;
    ds_d        = ds;
    din_d       = din;
    chip_ack_d  = 1'b0;
    cpu_ack_d   = 1'b0;
    chip_dout_d = chip_dout;
    cpu_dout_d  = cpu_dout;
    sync_d      = ready && (slot_cnt_d < SYNC_END);
    if (!ready) begin
      cs_d = 1'b0;
    end else begin
      // dout is captured from the DOUT_LAT cycle; ack and data appear together
      // on the following cycle. Uses the grant of the slot now ending.
      if (slot_cnt == DOUT_IDX) begin
        if (grant == GNT_CHIP) begin
          chip_ack_d = 1'b1;
          if (!we) chip_dout_d = dout;
        end
        if (grant == GNT_CPU) begin
          cpu_ack_d = 1'b1;
          if (!we) cpu_dout_d = dout;
        end
      end
      if (slot_start) begin
        case (grant_d)
          GNT_REF: begin
            cs_d      = 1'b1;
            refresh_d = 1'b1;
            we_d      = 1'b0;
          end
          GNT_CHIP: begin
            cs_d      = 1'b1;
            refresh_d = 1'b0;
            we_d      = chip_we;
            addr_d    = chip_addr;
            ds_d      = chip_ds;
            din_d     = chip_din;
          end
          GNT_CPU: begin
            cs_d      = 1'b1;
            refresh_d = 1'b0;
            we_d      = cpu_we;
            addr_d    = cpu_addr;
            ds_d      = cpu_ds;
            din_d     = cpu_din;
          end
          default: cs_d = 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_slot_arbiter
// Description : Self-checking bench for sdram_slot_arbiter. A slot-level
//               reference model predicts every output each cycle; directed
//               scenarios are followed by a randomized client/ready phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_slot_arbiter;

  localparam int N    = 10;
  localparam int LAT  = 8;
  localparam int RSL  = 32;
  localparam int RMAX = 4;

  localparam int G_NONE = 0;
  localparam int G_REF  = 1;
  localparam int G_CHIP = 2;
  localparam int G_CPU  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ready = 1'b0;
  logic        sync, cs, we, refresh;
  logic [21:0] addr;
  logic [1:0]  ds;
  logic [15:0] din;
  logic [15:0] dout = '0;
  logic        chip_req = 1'b0, chip_we = 1'b0;
  logic [21:0] chip_addr = '0;
  logic [1:0]  chip_ds = '0;
  logic [15:0] chip_din = '0;
  logic        chip_ack;
  logic [15:0] chip_dout;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [1:0]  cpu_ds = '0;
  logic [15:0] cpu_din = '0;
  logic        cpu_ack;
  logic [15:0] cpu_dout;

  sdram_slot_arbiter #(
    .SLOT_CYCLES(N), .DOUT_LAT(LAT), .REFRESH_SLOTS(RSL), .REFRESH_MAX(RMAX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready),
    .sync(sync), .cs(cs), .we(we), .refresh(refresh),
    .addr(addr), .ds(ds), .din(din), .dout(dout),
    .chip_req(chip_req), .chip_we(chip_we), .chip_addr(chip_addr),
    .chip_ds(chip_ds), .chip_din(chip_din), .chip_ack(chip_ack),
    .chip_dout(chip_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_ds(cpu_ds), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .cpu_dout(cpu_dout)
  );

  always #5 clk = ~clk;

  // Reference model state: position inside the slot plus per-slot decisions.
  int          m_phase, m_grant, m_slots, m_defer;
  bit          m_active, m_pend;
  logic        m_cs, m_we, m_ref, m_chip_ack, m_cpu_ack;
  logic [21:0] m_addr;
  logic [1:0]  m_ds;
  logic [15:0] m_din, m_chip_dout, m_cpu_dout;

  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  bit          rand_en = 1'b0;
  bit          chip_keep = 1'b0;
  logic [15:0] lat_dout = 16'h0000;

  task automatic model_reset();
    m_phase = 0; m_grant = G_NONE; m_slots = 0; m_defer = 0;
    m_active = 1'b0; m_pend = 1'b0;
    m_cs = 1'b0; m_we = 1'b0; m_ref = 1'b0; m_chip_ack = 1'b0; m_cpu_ack = 1'b0;
    m_addr = '0; m_ds = '0; m_din = '0; m_chip_dout = '0; m_cpu_dout = '0;
  endtask

  // Slot-start decision from the arbitration rules. Refresh requests mature
  // every RSL-th slot, counted over slots that actually started.
  task automatic model_slot_start();
    bit mature;
    mature = ((m_slots % RSL) == RSL - 1);
    if (m_pend && (m_defer == RMAX || !chip_req)) begin
      m_grant = G_REF; m_cs = 1'b1; m_ref = 1'b1; m_we = 1'b0;
      m_pend = 1'b0; m_defer = 0;
    end else if (chip_req) begin
      m_grant = G_CHIP; m_cs = 1'b1; m_ref = 1'b0; m_we = chip_we;
      m_addr = chip_addr; m_ds = chip_ds; m_din = chip_din;
      if (m_pend) m_defer = m_defer + 1;
    end else if (cpu_req) begin
      m_grant = G_CPU; m_cs = 1'b1; m_ref = 1'b0; m_we = cpu_we;
      m_addr = cpu_addr; m_ds = cpu_ds; m_din = cpu_din;
    end else begin
      m_grant = G_NONE; m_cs = 1'b0;
    end
    if (mature) m_pend = 1'b1;
    m_slots = m_slots + 1;
  endtask

  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic model_edge();
    if (!ready) begin
      m_phase = 0; m_active = 1'b0; m_grant = G_NONE; m_cs = 1'b0;
      m_chip_ack = 1'b0; m_cpu_ack = 1'b0;
    end else begin
      m_chip_ack = (m_phase == LAT) && (m_grant == G_CHIP);
      m_cpu_ack  = (m_phase == LAT) && (m_grant == G_CPU);
      if (m_chip_ack && !m_we) m_chip_dout = dout;
      if (m_cpu_ack && !m_we)  m_cpu_dout = dout;
      if (!m_active || m_phase == N - 1) model_slot_start();
      m_phase  = (m_phase + 1) % N;
      m_active = 1'b1;
    end
  endtask

  task automatic check_outputs(string tag);
    logic [77:0] obs, exp;
    obs = {sync, cs, we, refresh, addr, ds, din, chip_ack, chip_dout, cpu_ack, cpu_dout};
    exp = {(m_active && (m_phase < N / 2)), m_cs, m_we, m_ref, m_addr, m_ds, m_din,
           m_chip_ack, m_chip_dout, m_cpu_ack, m_cpu_dout};
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_chip();
    chip_req = 1'b1; chip_we = 1'($urandom); chip_addr = 22'($urandom);
    chip_ds = 2'($urandom); chip_din = 16'($urandom);
  endtask

  task automatic new_cpu();
    cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 22'($urandom);
    cpu_ds = 2'($urandom); cpu_din = 16'($urandom);
  endtask

  // Client behaviour: hold until ack, then drop (or re-request when asked to).
  task automatic drive_inputs();
    if (m_chip_ack) begin
      if (chip_keep) new_chip();
      else chip_req = 1'b0;
    end else if (rand_en && !chip_req && $urandom_range(0, 3) == 0) begin
      new_chip();
    end
    if (m_cpu_ack) cpu_req = 1'b0;
    else if (rand_en && !cpu_req && $urandom_range(0, 2) == 0) new_cpu();
    if (rand_en) begin
      lat_dout = 16'($urandom);
      if (ready && $urandom_range(0, 299) == 0) ready = 1'b0;
      else if (!ready && $urandom_range(0, 3) == 0) ready = 1'b1;
    end
    dout = (m_active && m_phase == LAT) ? lat_dout : 16'($urandom);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cycle = cycle + 1;
    check_outputs("cycle");
    drive_inputs();
  endtask

  initial begin
    int ref_cycles;
    int wait_cnt;
    int gap;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_state");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();   // ready low: nothing moves

    // Idle: one refresh slot appears after RSL slots.
    ready = 1'b1;
    ref_cycles = 0;
    for (int i = 0; i < N * 34; i++) begin
      step();
      if (cs === 1'b1 && refresh === 1'b1) ref_cycles++;
    end
    check_val("idle_refresh_cycles", 32'(ref_cycles), 32'(N));

    // CPU read with known data at the capture offset.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h12345; cpu_ds = 2'b00;
    cpu_din = 16'h0000; lat_dout = 16'hBEEF;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end while (!m_cpu_ack && wait_cnt < 3 * N);
    check_val("cpu_read_ack", 32'(cpu_ack), 32'd1);
    check_val("cpu_read_data", 32'(cpu_dout), 32'hBEEF);
    check_val("cpu_read_addr", 32'(addr), 32'h12345);
    check_val("cpu_read_we", 32'(we), 32'd0);

    // Chip write racing a CPU read: chip first, CPU exactly one slot later.
    chip_req = 1'b1; chip_we = 1'b1; chip_addr = 22'h0ABCD; chip_ds = 2'b01;
    chip_din = 16'hA55A;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h3AAAA; cpu_ds = 2'b11;
    lat_dout = 16'h1234;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end while (!m_chip_ack && wait_cnt < 3 * N);
    check_val("chip_write_ack", 32'(chip_ack), 32'd1);
    check_val("chip_write_din", 32'(din), 32'hA55A);
    check_val("chip_write_ds", 32'(ds), 32'd1);
    check_val("chip_write_dout_kept", 32'(chip_dout), 32'h0);
    gap = 0;
    do begin step(); gap++; end while (!m_cpu_ack && gap < 3 * N);
    check_val("cpu_after_chip_gap", 32'(gap), 32'(N));
    check_val("cpu_after_chip_data", 32'(cpu_dout), 32'h1234);

    // Continuous chipset traffic across a refresh deadline.
    chip_keep = 1'b1;
    new_chip();
    ref_cycles = 0;
    for (int i = 0; i < N * 45; i++) begin
      step();
      if (cs === 1'b1 && refresh === 1'b1) ref_cycles++;
    end
    check_val("forced_refresh_cycles", 32'(ref_cycles), 32'(N));
    chip_keep = 1'b0;
    for (int i = 0; i < 2 * N; i++) step();

    // Reset in the middle of a CPU read slot.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h00777; cpu_ds = 2'b10;
    lat_dout = 16'hC0DE;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end
      while (!(m_grant == G_CPU && m_phase == 5) && wait_cnt < 4 * N);
    check_val("reset_mid_slot_reached", 32'(wait_cnt < 4 * N), 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset_clear");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outputs("held_in_reset");
    end
    reset_n = 1'b1;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end while (!m_cpu_ack && wait_cnt < 3 * N);
    check_val("cpu_after_reset_ack", 32'(cpu_ack), 32'd1);
    check_val("cpu_after_reset_data", 32'(cpu_dout), 32'hC0DE);

    // ready drops mid-slot for 20 cycles while a CPU read is granted.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h2F0F0; cpu_ds = 2'b00;
    lat_dout = 16'h5AA5;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end
      while (!(m_grant == G_CPU && m_phase == 3) && wait_cnt < 4 * N);
    ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_val("ready_low_sync_cs", {30'd0, sync, cs}, 32'd0);
    ready = 1'b1;
    wait_cnt = 0;
    do begin step(); wait_cnt++; end while (!m_cpu_ack && wait_cnt < 3 * N);
    check_val("cpu_after_ready_data", 32'(cpu_dout), 32'h5AA5);

    // Randomized clients and occasional ready drops.
    rand_en = 1'b1;
    for (int i = 0; i < N * 300; i++) step();
    rand_en = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 2 * N; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
